noc_rr_timeout_arbiter: RTL and testbench

- Output-port arbiter for the NoC router; parametrised successor of the fixed 5-port L/N/E/W/S arbiter.
- Grants one of NPORTS input ports using round-robin priority and holds the grant for a whole packet.
- Releases on tail-flit transfer, request drop, or per-port timeout (limit latched from the head flit).
- Adds a registered one-hot grant, a grant index, timeout pulses, and timeout-disable (limit 0).

---
 rtl/noc_rr_timeout_arbiter_pkg.sv | 22 ++
 rtl/noc_rr_timeout_arbiter_if.sv | 30 +++
 rtl/noc_rr_timeout_arbiter_pkt_timer.sv | 45 ++++
 rtl/noc_rr_timeout_arbiter.sv | 114 +++++++++++
 tb/tb_noc_rr_timeout_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/noc_rr_timeout_arbiter_pkg.sv
// Shared constants and helpers for the NoC output-port arbiter slice.
package noc_arb_pkg;

  localparam logic [2:0] HEAD_ID = 3'b001;
  localparam logic [2:0] TAIL_ID = 3'b100;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'd0,
    FLIT_BODY = 2'd1,
    FLIT_TAIL = 2'd2
  } flit_type_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_rr_timeout_arbiter_if.sv
// Request/grant bundle between input ports (master side) and the output-port arbiter (slave side).
interface noc_rr_timeout_arbiter_if #(
  parameter int NPORTS = 5,
  parameter int LEN_W  = 12,
  parameter int FID_W  = 3
);
  import noc_arb_pkg::*;

  localparam int IDX_W = clog2(NPORTS);

  logic [NPORTS-1:0]       req;
  logic [NPORTS*FID_W-1:0] flit_id;
  logic [NPORTS*LEN_W-1:0] length;
  logic                    fwd_ack;
  logic [NPORTS-1:0]       grant;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic [NPORTS-1:0]       timeout_pulse;

  modport master (
    output req, flit_id, length, fwd_ack,
    input  grant, grant_valid, grant_idx, timeout_pulse
  );

  modport slave (
    input  req, flit_id, length, fwd_ack,
    output grant, grant_valid, grant_idx, timeout_pulse
  );

endinterface

// File: rtl/noc_rr_timeout_arbiter_pkt_timer.sv
// Per-port packet timer: latches the timeout limit from head flits and counts cycles while granted.
module noc_pkt_timer #(
  parameter int               LEN_W   = 12,
  parameter int               FID_W   = 3,
  parameter logic [FID_W-1:0] HEAD_ID = noc_arb_pkg::HEAD_ID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FID_W-1:0] flit_id,
  input  logic [LEN_W-1:0] length,
  input  logic             run,
  output logic             expire
);

  logic [LEN_W-1:0] limit_r;
  logic [LEN_W-1:0] count_r;

  // Limit latch: any head flit refreshes the limit, whether or not the port holds the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      limit_r <= '0;
    end else if (flit_id == HEAD_ID) begin
      limit_r <= length;
    end else begin
      limit_r <= limit_r;
    end
  end

  // Hold counter: zero on the first granted cycle, saturating, cleared whenever not holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (!run) begin
      count_r <= '0;
    end else if (count_r != {LEN_W{1'b1}}) begin
      count_r <= count_r + LEN_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // A zero limit disables the timeout; otherwise the grant lasts exactly limit cycles.
  assign expire = run && (limit_r != '0) && (count_r == (limit_r - LEN_W'(1)));

endmodule

// File: rtl/noc_rr_timeout_arbiter.sv
// Round-robin output-port arbiter holding the grant per packet, with tail, request-drop and timeout release.
module noc_rr_timeout_arbiter #(
  parameter int               NPORTS  = 5,
  parameter int               LEN_W   = 12,
  parameter int               FID_W   = 3,
  parameter logic [FID_W-1:0] HEAD_ID = noc_arb_pkg::HEAD_ID,
  parameter logic [FID_W-1:0] TAIL_ID = noc_arb_pkg::TAIL_ID
) (
  input logic                     clk,
  input logic                     rst,
  noc_rr_timeout_arbiter_if.slave arb
);
  import noc_arb_pkg::*;

  localparam int               IDX_W    = clog2(NPORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPORTS - 1);

  logic [NPORTS-1:0] grant_r, pulse_r, expire_s, tail_s, eligible_s, grant_n_s, pulse_n_s;
  logic [IDX_W-1:0]  idx_r, ptr_r, pick_s, idx_n_s, ptr_n_s, cand_idx_s;
  logic              valid_r, found_s, held_s, hold_req_s, hold_tail_s, hold_exp_s;
  logic              release_s, timeout_s;
  int                cand_s;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    noc_pkt_timer #(
      .LEN_W   (LEN_W),
      .FID_W   (FID_W),
      .HEAD_ID (HEAD_ID)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .flit_id (arb.flit_id[i*FID_W +: FID_W]),
      .length  (arb.length[i*LEN_W +: LEN_W]),
      .run     (grant_r[i]),
      .expire  (expire_s[i])
    );
    assign tail_s[i] = (arb.flit_id[i*FID_W +: FID_W] == TAIL_ID);
  end

  assign held_s      = |grant_r;
  assign hold_req_s  = |(grant_r & arb.req);
  assign hold_tail_s = arb.fwd_ack && (|(grant_r & tail_s));
  assign hold_exp_s  = |(grant_r & expire_s);
  assign release_s   = held_s && (!hold_req_s || hold_tail_s || hold_exp_s);
  // Only a pure expiry counts as a timeout; tail or request drop in the same cycle take precedence.
  assign timeout_s   = held_s && hold_exp_s && hold_req_s && !hold_tail_s;
  assign eligible_s  = arb.req & ~(release_s ? grant_r : {NPORTS{1'b0}});

  // Round-robin search starting just after the last holder.
  always_comb begin
    found_s    = 1'b0;
    pick_s     = '0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand_s     = int'(ptr_r) + k;
      cand_s     = (cand_s >= NPORTS) ? (cand_s - NPORTS) : cand_s;
      cand_idx_s = IDX_W'(cand_s);
      if (!found_s && eligible_s[cand_idx_s]) begin
        found_s = 1'b1;
        pick_s  = cand_idx_s;
      end else begin
        found_s = found_s;
        pick_s  = pick_s;
      end
    end
  end

  // Next grant state: re-arbitrate when idle or releasing, otherwise keep the holder.
  always_comb begin
    grant_n_s = grant_r;
    idx_n_s   = idx_r;
    ptr_n_s   = ptr_r;
    pulse_n_s = timeout_s ? grant_r : {NPORTS{1'b0}};
    if (!held_s || release_s) begin
      if (found_s) begin
        grant_n_s = {{(NPORTS-1){1'b0}}, 1'b1} << pick_s;
        idx_n_s   = pick_s;
        ptr_n_s   = pick_s;
      end else begin
        grant_n_s = '0;
        idx_n_s   = '0;
        ptr_n_s   = ptr_r;
      end
    end else begin
      grant_n_s = grant_r;
      idx_n_s   = idx_r;
      ptr_n_s   = ptr_r;
    end
  end

  // Output and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r <= '0;
      valid_r <= 1'b0;
      idx_r   <= '0;
      ptr_r   <= LAST_IDX;
      pulse_r <= '0;
    end else begin
      grant_r <= grant_n_s;
      valid_r <= |grant_n_s;
      idx_r   <= idx_n_s;
      ptr_r   <= ptr_n_s;
      pulse_r <= pulse_n_s;
    end
  end

  assign arb.grant         = grant_r;
  assign arb.grant_valid   = valid_r;
  assign arb.grant_idx     = idx_r;
  assign arb.timeout_pulse = pulse_r;

endmodule

// File: tb/tb_noc_rr_timeout_arbiter.sv
// Directed scoreboard bench for noc_rr_timeout_arbiter: stimulus queues expectations, a monitor checks each cycle.
module tb_noc_rr_timeout_arbiter;

  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  noc_rr_timeout_arbiter_if #(.NPORTS(5), .LEN_W(12), .FID_W(3)) bus ();

  noc_rr_timeout_arbiter #(.NPORTS(5), .LEN_W(12), .FID_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] fid1(input int p, input logic [2:0] v);
    logic [14:0] f;
    f = {5{BODY}};
    f[p*3 +: 3] = v;
    return f;
  endfunction

  function automatic logic [59:0] len1(input int p, input logic [11:0] l);
    logic [59:0] x;
    x = '0;
    x[p*12 +: 12] = l;
    return x;
  endfunction

  function automatic logic [2:0] idx_of(input logic [4:0] g);
    for (int i = 0; i < 5; i++) begin
      if (g[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic cyc(input logic r, input logic [4:0] rq, input logic [14:0] fid,
                     input logic [59:0] len, input logic ack,
                     input logic [4:0] eg, input logic [4:0] ep, input string tag);
    rst          = r;
    bus.req      = rq;
    bus.flit_id  = fid;
    bus.length   = len;
    bus.fwd_ack  = ack;
    exp_q.push_back({eg, ep});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 5'b00000, {5{BODY}}, '0, 1'b0, 5'b00000, 5'b00000, "reset");
  endtask

  // Monitor: one expectation is consumed per cycle, checked mid-cycle.
  initial begin
    logic [9:0] e;
    string      t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (bus.grant !== e[9:5]) begin
          errors++;
          $display("FAIL %s grant got %b want %b @%0t", t, bus.grant, e[9:5], $time);
        end
        checks++;
        if (bus.grant_idx !== idx_of(e[9:5])) begin
          errors++;
          $display("FAIL %s grant_idx got %0d want %0d @%0t", t, bus.grant_idx, idx_of(e[9:5]), $time);
        end
        checks++;
        if (bus.grant_valid !== (|e[9:5])) begin
          errors++;
          $display("FAIL %s grant_valid got %b want %b @%0t", t, bus.grant_valid, |e[9:5], $time);
        end
        checks++;
        if (bus.timeout_pulse !== e[4:0]) begin
          errors++;
          $display("FAIL %s timeout_pulse got %b want %b @%0t", t, bus.timeout_pulse, e[4:0], $time);
        end
      end
    end
  end

  initial begin
    logic [4:0] g;
    checks = 0;
    errors = 0;

    do_reset();
    do_reset();

    // Single requester with no limit is held indefinitely, then released by request drop.
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 5'b00100, {5{BODY}}, '0, 1'b0, 5'b00100, 5'b00000, "single");
    cyc(1'b0, 5'b00000, {5{BODY}}, '0, 1'b0, 5'b00000, 5'b00000, "single_drop");

    // Round-robin over all ports, each packet closed by a tail.
    do_reset();
    cyc(1'b0, 5'b11111, {5{BODY}}, '0, 1'b0, 5'b00001, 5'b00000, "rr_first");
    for (int p = 0; p < 5; p++) begin
      g = 5'b00001 << ((p + 1) % 5);
      cyc(1'b0, 5'b11111, fid1(p, TAIL), '0, 1'b1, g, 5'b00000, "rr_tail");
    end

    // Timeout of port 1 with port 3 waiting.
    do_reset();
    cyc(1'b0, 5'b01010, fid1(1, HEAD), len1(1, 12'd4), 1'b0, 5'b00010, 5'b00000, "to_grant");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 5'b01010, {5{BODY}}, '0, 1'b0, 5'b00010, 5'b00000, "to_hold");
    cyc(1'b0, 5'b01010, {5{BODY}}, '0, 1'b0, 5'b01000, 5'b00010, "to_move");
    cyc(1'b0, 5'b01010, {5{BODY}}, '0, 1'b0, 5'b01000, 5'b00000, "to_after");

    // Timeout of a sole requester: one idle cycle, then re-granted.
    do_reset();
    cyc(1'b0, 5'b00010, fid1(1, HEAD), len1(1, 12'd4), 1'b0, 5'b00010, 5'b00000, "solo_grant");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 5'b00010, {5{BODY}}, '0, 1'b0, 5'b00010, 5'b00000, "solo_hold");
    cyc(1'b0, 5'b00010, {5{BODY}}, '0, 1'b0, 5'b00000, 5'b00010, "solo_idle");
    cyc(1'b0, 5'b00010, {5{BODY}}, '0, 1'b0, 5'b00010, 5'b00000, "solo_regrant");
    cyc(1'b0, 5'b00010, {5{BODY}}, '0, 1'b0, 5'b00010, 5'b00000, "solo_regrant2");

    // Tail on the expiring cycle: release without a timeout pulse.
    do_reset();
    cyc(1'b0, 5'b00001, fid1(0, HEAD), len1(0, 12'd3), 1'b0, 5'b00001, 5'b00000, "tt_grant");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 5'b00001, {5{BODY}}, '0, 1'b0, 5'b00001, 5'b00000, "tt_hold");
    cyc(1'b0, 5'b00001, fid1(0, TAIL), '0, 1'b1, 5'b00000, 5'b00000, "tt_release");
    cyc(1'b0, 5'b00001, {5{BODY}}, '0, 1'b0, 5'b00001, 5'b00000, "tt_regrant");

    // Request drop mid-packet moves the grant, then goes idle.
    do_reset();
    cyc(1'b0, 5'b00011, {5{BODY}}, '0, 1'b0, 5'b00001, 5'b00000, "drop_grant");
    cyc(1'b0, 5'b00011, {5{BODY}}, '0, 1'b0, 5'b00001, 5'b00000, "drop_hold");
    cyc(1'b0, 5'b00010, {5{BODY}}, '0, 1'b0, 5'b00010, 5'b00000, "drop_move");
    cyc(1'b0, 5'b00000, {5{BODY}}, '0, 1'b0, 5'b00000, 5'b00000, "drop_idle");

    // Request drop coinciding with expiry: no pulse.
    do_reset();
    cyc(1'b0, 5'b00001, fid1(0, HEAD), len1(0, 12'd2), 1'b0, 5'b00001, 5'b00000, "dx_grant");
    cyc(1'b0, 5'b00001, {5{BODY}}, '0, 1'b0, 5'b00001, 5'b00000, "dx_hold");
    cyc(1'b0, 5'b00000, {5{BODY}}, '0, 1'b0, 5'b00000, 5'b00000, "dx_release");

    // Reset while port 3 holds: everything clears, arbitration restarts at port 0.
    do_reset();
    cyc(1'b0, 5'b01000, {5{BODY}}, '0, 1'b0, 5'b01000, 5'b00000, "mr_grant");
    cyc(1'b0, 5'b01000, {5{BODY}}, '0, 1'b0, 5'b01000, 5'b00000, "mr_hold");
    cyc(1'b1, 5'b11111, {5{BODY}}, '0, 1'b0, 5'b00000, 5'b00000, "mr_reset");
    cyc(1'b0, 5'b11111, {5{BODY}}, '0, 1'b0, 5'b00001, 5'b00000, "mr_restart");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
